gpr_wr_arbiter: RTL and testbench

//  Shares the single GPR write port (Rd_wr/Rd_addr/Rd_data into gpr) between NUM_REQ write-back requesters.

---
 rtl/gpr_wr_arbiter.sv | 101 ++++++++++
 tb/tb_gpr_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gpr_wr_arbiter.sv
// rtl/gpr_wr_arbiter.sv - GPR write-port arbiter (round-robin when GPR_ARB_RR_EN is defined, else fixed priority)
module gpr_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GPR_ASZ = 5,
  parameter int RSZ     = 32,
  parameter int CNT_W   = 16
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][GPR_ASZ-1:0]        req_addr,
  input  logic [NUM_REQ-1:0][RSZ-1:0]            req_data,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   Rd_wr,
  output logic [GPR_ASZ-1:0]                     Rd_addr,
  output logic [RSZ-1:0]                         Rd_data,
  output logic [$clog2(NUM_REQ)-1:0]             last_grant,
  output logic [CNT_W-1:0]                       contend_cnt
);

  localparam int GW = $clog2(NUM_REQ);

  logic [GW-1:0]      ptr;
  logic [GW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               xfer;
  logic               multi;
  logic               wr_q;
  logic [GPR_ASZ-1:0] win_addr;
  int                 sel_idx;
  int                 nvalid;

`ifdef GPR_ARB_RR_EN
  // Rotate the search start to just past the most recent winner
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Search requesters starting at ptr, wrapping; first valid one wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_idx = int'(ptr) + k;
      if (sel_idx >= NUM_REQ) sel_idx = sel_idx - NUM_REQ;
      if (!gnt_any && req_valid[sel_idx[GW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sel_idx[GW-1:0];
      end
    end
  end

  // One-hot ready, suppressed entirely while reset is held
  always_comb begin
    req_ready = '0;
    if (reset_in && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Count simultaneous requesters for the contention statistic
  always_comb begin
    nvalid = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) nvalid = nvalid + 1;
    end
  end

  assign multi    = (nvalid > 1);
  assign xfer     = reset_in & gnt_any;
  assign win_addr = req_addr[gnt_idx];

  // Register the winning write; x0 writes are accepted but never strobed
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_q        <= 1'b0;
      Rd_addr     <= '0;
      Rd_data     <= '0;
      last_grant  <= '0;
      contend_cnt <= '0;
    end else begin
      wr_q <= xfer && (win_addr != '0);
      if (xfer && (win_addr != '0)) begin
        Rd_addr <= win_addr;
        Rd_data <= req_data[gnt_idx];
      end
      if (xfer) last_grant <= gnt_idx;
      if (multi && (contend_cnt != '1)) contend_cnt <= contend_cnt + 1'b1;
    end
  end

  // A write registered just before reset must not reach the GPR file
  assign Rd_wr = wr_q & reset_in;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// tb/tb_gpr_wr_arbiter.sv - self-checking bench for gpr_wr_arbiter
module tb_gpr_wr_arbiter;

  logic               clk_in = 1'b0;
  logic               reset_in;
  logic [2:0]         req_valid;
  logic [2:0][4:0]    req_addr;
  logic [2:0][31:0]   req_data;
  logic [2:0]         req_ready;
  logic               Rd_wr;
  logic [4:0]         Rd_addr;
  logic [31:0]        Rd_data;
  logic [1:0]         last_grant;
  logic [15:0]        contend_cnt;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q[$];
  logic [1:0]  mptr;
  logic [1:0]  mlast;
  logic [15:0] mcnt;

  gpr_wr_arbiter dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .Rd_wr       (Rd_wr),
    .Rd_addr     (Rd_addr),
    .Rd_data     (Rd_data),
    .last_grant  (last_grant),
    .contend_cnt (contend_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, predict grant, check, then advance the model
  task automatic cycle(input logic rst, input logic [2:0] v,
                       input logic [2:0][4:0] a, input logic [2:0][31:0] d);
    int g;
    int idx;
    int pc;
    logic [2:0] er;
    reset_in  = rst;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    if (!rst) exp_q.delete();
    g = -1;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        idx = (int'(mptr) + k) % 3;
        if (g < 0 && (((v >> idx) & 3'b001) != 3'b000)) g = idx;
      end
    end
    er = (g >= 0) ? (3'b001 << g) : 3'b000;
    pc = $countones(v);
    @(negedge clk_in);
    chk("ready", 64'(req_ready), 64'(er));
    chk("last_grant", 64'(last_grant), 64'(mlast));
    chk("contend_cnt", 64'(contend_cnt), 64'(mcnt));
    if (g >= 0 && a[g[1:0]] != 5'd0) exp_q.push_back({a[g[1:0]], d[g[1:0]]});
    @(posedge clk_in);
    #1;
    if (!rst) begin
      mptr  = 2'd0;
      mlast = 2'd0;
      mcnt  = 16'd0;
    end else begin
      if (g >= 0) begin
        mlast = g[1:0];
`ifdef GPR_ARB_RR_EN
        mptr = (g == 2) ? 2'd0 : 2'(g + 1);
`endif
      end
      if (pc > 1 && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    end
  endtask

  // Scoreboard drain and bus invariants, sampled on the falling edge
  always @(negedge clk_in) begin
    logic [36:0] e;
    chk("onehot0_ready", 64'($onehot0(req_ready)), 64'd1);
    if (reset_in === 1'b0) chk("rd_wr_in_reset", 64'(Rd_wr), 64'd0);
    if (Rd_wr === 1'b1) begin
      chk("rd_known", 64'($isunknown({Rd_addr, Rd_data})), 64'd0);
      chk("rd_addr_nonzero", 64'(Rd_addr != 5'd0), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(Rd_addr), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(Rd_addr), 64'(e[36:32]));
        chk("wr_data", 64'(Rd_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    logic [2:0][4:0]  za;
    logic [2:0][31:0] zd;
    za        = '0;
    zd        = '0;
    reset_in  = 1'b0;
    req_valid = 3'b000;
    req_addr  = '0;
    req_data  = '0;
    mptr      = 2'd0;
    mlast     = 2'd0;
    mcnt      = 16'd0;
    @(posedge clk_in);
    #1;

    // Reset held with every requester asking
    repeat (3) cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});

`ifdef GPR_ARB_RR_EN
    repeat (6) cycle(1'b1, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000});
    chk("contend_six", 64'(contend_cnt), 64'd6);
`else
    repeat (3) cycle(1'b1, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000});
    chk("contend_three", 64'(contend_cnt), 64'd3);
`endif

    // Single write lands one cycle later
    cycle(1'b1, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEAD_BEEF});
    chk("single_rd_wr", 64'(Rd_wr), 64'd1);
    chk("single_rd_addr", 64'(Rd_addr), 64'd5);
    chk("single_rd_data", 64'(Rd_data), 64'hDEAD_BEEF);

    // x0 write is accepted but never strobed
    cycle(1'b1, 3'b010, za, {32'h0, 32'h5555_5555, 32'h0});
    chk("x0_last_grant", 64'(last_grant), 64'd1);
    chk("x0_rd_wr", 64'(Rd_wr), 64'd0);

    // Same address from two requesters back to back
    cycle(1'b1, 3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hBBBB_0007, 32'hAAAA_0007});
    cycle(1'b1, 3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hBBBB_0007, 32'hAAAA_0007});
    cycle(1'b1, 3'b000, za, zd);

    // Mixed traffic
    repeat (40) cycle(1'b1, 3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom});
    cycle(1'b1, 3'b000, za, zd);

    // Contention counter saturation
    repeat (65540) cycle(1'b1, 3'b011, za, zd);
    chk("cnt_saturated", 64'(contend_cnt), 64'hFFFF);

    // Reset arriving right after a grant discards the write
    cycle(1'b1, 3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h1234_5678});
    cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
    chk("post_reset_cnt", 64'(contend_cnt), 64'd0);
    chk("post_reset_rd_wr", 64'(Rd_wr), 64'd0);
    cycle(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
    chk("post_reset_grant", 64'(last_grant), 64'd0);
    repeat (2) cycle(1'b1, 3'b000, za, zd);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
